// File: rtl/nn_pkg.sv
// rtl/nn_pkg.sv - shared FP32 constants and bank-state type for the dense-layer datapath
package nn_pkg;

  localparam int FP32_W     = 32;
  localparam int DEF_FAN_IN = 30;

  localparam logic [FP32_W-1:0] FP32_ZERO = 32'h0000_0000;

  typedef enum logic [1:0] {
    EMPTY   = 2'd0,
    FILLING = 2'd1,
    FULL    = 2'd2
  } bank_state_e;

endpackage

// File: rtl/act_bank.sv
// rtl/act_bank.sv - one NUM_IN x DW activation register bank with indexed write, clear and zero-pad
module act_bank
  import nn_pkg::*;
#(
  parameter int NUM_IN = DEF_FAN_IN,
  parameter int DW     = FP32_W
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       we,
  input  logic [$clog2(NUM_IN)-1:0]  widx,
  input  logic [DW-1:0]              wdata,
  input  logic                       clr,
  input  logic                       pad,
  output logic [NUM_IN*DW-1:0]       rd_flat
);

  logic [NUM_IN-1:0][DW-1:0] mem_q;
  logic [NUM_IN-1:0][DW-1:0] mem_d;

  // Next contents: clear wins; otherwise write one word and, when padding, zero every later slot
  always_comb begin
    mem_d = mem_q;
    if (clr) begin
      mem_d = '0;
    end else begin
      for (int k = 0; k < NUM_IN; k++) begin
        if (we && (int'(widx) == k)) begin
          mem_d[k] = wdata;
        end else if (pad && (k > int'(widx))) begin
          mem_d[k] = FP32_ZERO;
        end
      end
    end
  end

  // Bank storage register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '0;
    end else begin
      mem_q <= mem_d;
    end
  end

  assign rd_flat = mem_q;

endmodule

// File: rtl/act_vector_loader.sv
// rtl/act_vector_loader.sv - double-buffered serial-to-vector FP32 activation loader (option macro: ACT_LOADER_ZERO_PAD_EN)
module act_vector_loader
  import nn_pkg::*;
#(
  parameter int NUM_IN = DEF_FAN_IN,
  parameter int DW     = FP32_W
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DW-1:0]        s_data,
  input  logic                 s_valid,
  input  logic                 s_last,
  output logic                 s_ready,
  output logic [NUM_IN*DW-1:0] vec_out,
  output logic                 vec_valid,
  input  logic                 vec_ready,
  output logic                 err_len
);

  localparam int            IW       = $clog2(NUM_IN);
  localparam logic [IW-1:0] LAST_IDX = IW'(NUM_IN - 1);

  bank_state_e          state_q [2];
  bank_state_e          state_d [2];
  logic                 wr_bank_q, wr_bank_d;
  logic                 rd_bank_q, rd_bank_d;
  logic [IW-1:0]        wr_idx_q, wr_idx_d;
  logic                 run_q, run_d;
  logic                 vec_valid_q, vec_valid_d;
  logic                 err_len_q, err_len_d;
  logic [NUM_IN*DW-1:0] vec_out_q, vec_out_d;

  logic [1:0]           bank_we, bank_clr, bank_pad;
  logic [NUM_IN*DW-1:0] bank_rd [2];
  logic                 accept, rel, at_last, short_vec;

  // run_q keeps s_ready low until the first edge after reset release
  assign s_ready   = run_q & (state_q[wr_bank_q] != FULL);
  assign accept    = s_valid & s_ready;
  assign rel       = vec_valid_q & vec_ready;
  assign at_last   = (wr_idx_q == LAST_IDX);
  assign short_vec = s_last & ~at_last;

  // Bank state machines, pointers and write controls
  always_comb begin
    state_d   = state_q;
    wr_bank_d = wr_bank_q;
    rd_bank_d = rd_bank_q;
    wr_idx_d  = wr_idx_q;
    run_d     = 1'b1;
    err_len_d = 1'b0;
    bank_we   = 2'b00;
    bank_clr  = 2'b00;
    bank_pad  = 2'b00;

    // A FULL read bank can never be the bank being written, so release and fill never collide
    if (rel) begin
      state_d[rd_bank_q] = EMPTY;
      rd_bank_d          = ~rd_bank_q;
    end

    if (accept) begin
      if (short_vec) begin
        err_len_d = 1'b1;
        wr_idx_d  = '0;
`ifdef ACT_LOADER_ZERO_PAD_EN
        bank_we[wr_bank_q]  = 1'b1;
        bank_pad[wr_bank_q] = 1'b1;
        state_d[wr_bank_q]  = FULL;
        wr_bank_d           = ~wr_bank_q;
`else
        bank_clr[wr_bank_q] = 1'b1;
        state_d[wr_bank_q]  = EMPTY;
`endif
      end else if (at_last) begin
        err_len_d          = ~s_last;
        bank_we[wr_bank_q] = 1'b1;
        state_d[wr_bank_q] = FULL;
        wr_bank_d          = ~wr_bank_q;
        wr_idx_d           = '0;
      end else begin
        bank_we[wr_bank_q] = 1'b1;
        state_d[wr_bank_q] = FILLING;
        wr_idx_d           = wr_idx_q + IW'(1);
      end
    end
  end

  // Output stage: valid/data are re-registered from the read bank; drop valid on the releasing edge
  always_comb begin
    vec_valid_d = (state_q[rd_bank_q] == FULL) & ~rel;
    vec_out_d   = bank_rd[rd_bank_q];
  end

  // Control and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q[0]  <= EMPTY;
      state_q[1]  <= EMPTY;
      wr_bank_q   <= 1'b0;
      rd_bank_q   <= 1'b0;
      wr_idx_q    <= '0;
      run_q       <= 1'b0;
      vec_valid_q <= 1'b0;
      err_len_q   <= 1'b0;
      vec_out_q   <= '0;
    end else begin
      state_q     <= state_d;
      wr_bank_q   <= wr_bank_d;
      rd_bank_q   <= rd_bank_d;
      wr_idx_q    <= wr_idx_d;
      run_q       <= run_d;
      vec_valid_q <= vec_valid_d;
      err_len_q   <= err_len_d;
      vec_out_q   <= vec_out_d;
    end
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    act_bank #(
      .NUM_IN (NUM_IN),
      .DW     (DW)
    ) u_bank (
      .clk     (clk),
      .rst_n   (rst_n),
      .we      (bank_we[b]),
      .widx    (wr_idx_q),
      .wdata   (s_data),
      .clr     (bank_clr[b]),
      .pad     (bank_pad[b]),
      .rd_flat (bank_rd[b])
    );
  end

  assign vec_valid = vec_valid_q;
  assign vec_out   = vec_out_q;
  assign err_len   = err_len_q;

endmodule

// File: tb/tb_act_vector_loader.sv
// tb/tb_act_vector_loader.sv - self-checking bench for act_vector_loader with a queue-based reference model
module tb_act_vector_loader;

  localparam int NUM_IN = 30;
  typedef logic [NUM_IN*32-1:0] vec_t;

  logic              clk = 1'b0;
  logic              rst_n;
  logic [31:0]       s_data;
  logic              s_valid, s_last, s_ready;
  vec_t              vec_out;
  logic              vec_valid, vec_ready, err_len;

  int   checks   = 0;
  int   failures = 0;
  bit   rdy_rand = 1'b0;

  // Reference model: words of the vector being assembled, and completed vectors awaiting release
  logic [31:0] cur [$];
  vec_t        pend [$];
  logic        err_exp  = 1'b0;
  logic        ready_en = 1'b0;
  int          stall    = 0;

  always #5 clk = ~clk;

  act_vector_loader #(.NUM_IN(NUM_IN), .DW(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .vec_out   (vec_out),
    .vec_valid (vec_valid),
    .vec_ready (vec_ready),
    .err_len   (err_len)
  );

  function automatic logic [31:0] fp(input int n);
    int          e;
    logic [31:0] m;
    e = 0;
    while ((n >> (e + 1)) != 0) e++;
    m = 32'((n - (1 << e)) << (23 - e));
    return {1'b0, 8'(127 + e), m[22:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic chk_vec(input string name, input vec_t act, input vec_t exp);
    checks++;
    if (act !== exp) begin
      failures++;
      for (int k = 0; k < NUM_IN; k++) begin
        if (act[k*32 +: 32] !== exp[k*32 +: 32]) begin
          $display("FAIL %s word=%0d actual=%h expected=%h", name, k, act[k*32 +: 32], exp[k*32 +: 32]);
          break;
        end
      end
    end
  endtask

  function automatic logic [31:0] word_of(input vec_t v, input int k);
    return v[k*32 +: 32];
  endfunction

  // Compare DUT against the model, then advance the model by the handshakes of the coming edge
  always @(negedge clk) begin
    logic exp_ready;
    vec_t v;
    if (!rst_n) begin
      chk("rst_vec_valid", 32'(vec_valid), 32'd0);
      chk("rst_s_ready", 32'(s_ready), 32'd0);
      chk("rst_err_len", 32'(err_len), 32'd0);
      chk_vec("rst_vec_out", vec_out, '0);
      cur.delete();
      pend.delete();
      err_exp  = 1'b0;
      ready_en = 1'b0;
      stall    = 0;
    end else begin
      exp_ready = ready_en && (pend.size() < 2);
      chk("s_ready", 32'(s_ready), 32'(exp_ready));
      chk("err_len", 32'(err_len), 32'(err_exp));
      if (vec_valid) begin
        stall = 0;
        if (pend.size() == 0) begin
          chk("spurious_vec_valid", 32'(vec_valid), 32'd0);
        end else begin
          chk_vec("vec_out", vec_out, pend[0]);
        end
      end else if (pend.size() > 0) begin
        stall++;
        checks++;
        if (stall >= 2) begin
          failures++;
          $display("FAIL vec_valid_latency actual=0 expected=1 pending=%0d", pend.size());
          stall = 0;
        end
      end

      err_exp = 1'b0;
      if (vec_valid && vec_ready && pend.size() > 0) void'(pend.pop_front());
      if (s_valid && exp_ready) begin
        cur.push_back(s_data);
        if (s_last && cur.size() < NUM_IN) begin
          err_exp = 1'b1;
`ifdef ACT_LOADER_ZERO_PAD_EN
          while (cur.size() < NUM_IN) cur.push_back(32'h0);
          for (int k = 0; k < NUM_IN; k++) v[k*32 +: 32] = cur[k];
          pend.push_back(v);
`endif
          cur.delete();
        end else if (cur.size() == NUM_IN) begin
          err_exp = !s_last;
          for (int k = 0; k < NUM_IN; k++) v[k*32 +: 32] = cur[k];
          pend.push_back(v);
          cur.delete();
        end
      end
      ready_en = 1'b1;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    if (rdy_rand) vec_ready = 1'($urandom_range(0, 1));
  endtask

  task automatic send(input logic [31:0] w, input logic l);
    bit ok;
    ok      = 1'b0;
    s_valid = 1'b1;
    s_data  = w;
    s_last  = l;
    for (int t = 0; t < 100; t++) begin
      ok = (s_ready === 1'b1);
      tick();
      if (ok) break;
    end
    s_valid = 1'b0;
    s_last  = 1'b0;
    checks++;
    if (!ok) begin
      failures++;
      $display("FAIL send_timeout actual=not_accepted expected=accepted word=%h", w);
    end
  endtask

  task automatic drain();
    int n;
    n         = 0;
    vec_ready = 1'b1;
    while ((pend.size() != 0 || vec_valid) && n < 50) begin
      tick();
      n++;
    end
    checks++;
    if (n >= 50) begin
      failures++;
      $display("FAIL drain_timeout actual=%0d expected=0", pend.size());
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; s_valid = 1'b0; s_last = 1'b0; s_data = '0; vec_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_s_ready_low", 32'(s_ready), 32'd0);
    rst_n = 1'b1;
    #1;
    chk("release_s_ready_low", 32'(s_ready), 32'd0);
    tick();
    chk("release_s_ready_high", 32'(s_ready), 32'd1);

    // 1.0f..30.0f, single vector, downstream always ready
    vec_ready = 1'b1;
    for (int i = 1; i <= NUM_IN; i++) send(fp(i), i == NUM_IN);
    chk("t1_valid_edge_t", 32'(vec_valid), 32'd0);
    tick();
    chk("t1_valid_edge_t1", 32'(vec_valid), 32'd1);
    chk("t1_word0", word_of(vec_out, 0), 32'h3F80_0000);
    chk("t1_word29", word_of(vec_out, 29), 32'h41F0_0000);
    chk("t1_err_len", 32'(err_len), 32'd0);
    tick();
    chk("t1_valid_one_cycle", 32'(vec_valid), 32'd0);

    // Two vectors back-to-back against a stalled consumer
    vec_ready = 1'b0;
    for (int i = 1; i <= 2 * NUM_IN; i++) send(fp(i), (i % NUM_IN) == 0);
    chk("t2_s_ready_both_full", 32'(s_ready), 32'd0);
    repeat (3) tick();
    chk("t2_hold_valid", 32'(vec_valid), 32'd1);
    chk("t2_hold_word0", word_of(vec_out, 0), fp(1));
    vec_ready = 1'b1;
    tick();
    vec_ready = 1'b0;
    chk("t2_s_ready_after_release", 32'(s_ready), 32'd1);
    chk("t2_bubble", 32'(vec_valid), 32'd0);
    tick();
    chk("t2_b_valid", 32'(vec_valid), 32'd1);
    chk("t2_b_word0", word_of(vec_out, 0), fp(31));
    drain();

    // Early s_last on word 10, then an intact vector
    for (int i = 1; i <= 10; i++) send(fp(100 + i), i == 10);
    chk("t3_err_pulse", 32'(err_len), 32'd1);
    tick();
    chk("t3_err_one_cycle", 32'(err_len), 32'd0);
`ifdef ACT_LOADER_ZERO_PAD_EN
    chk("t3_pad_valid", 32'(vec_valid), 32'd1);
    chk("t3_pad_word9", word_of(vec_out, 9), fp(110));
    chk("t3_pad_word10", word_of(vec_out, 10), 32'h0);
    chk("t3_pad_word29", word_of(vec_out, 29), 32'h0);
`else
    chk("t3_no_valid", 32'(vec_valid), 32'd0);
`endif
    drain();
    for (int i = 1; i <= NUM_IN; i++) send(fp(120 + i), i == NUM_IN);
    tick();
    chk("t3_next_valid", 32'(vec_valid), 32'd1);
    chk("t3_next_word0", word_of(vec_out, 0), fp(121));
    drain();

    // Full vector without s_last
    for (int i = 1; i <= NUM_IN; i++) send(fp(160 + i), 1'b0);
    chk("t5_err_pulse", 32'(err_len), 32'd1);
    tick();
    chk("t5_valid", 32'(vec_valid), 32'd1);
    chk("t5_word29", word_of(vec_out, 29), fp(190));
    drain();

    // Reset in the middle of a vector while another is held
    vec_ready = 1'b0;
    for (int i = 1; i <= NUM_IN; i++) send(fp(200 + i), i == NUM_IN);
    for (int i = 1; i <= 14; i++) send(fp(300 + i), 1'b0);
    chk("t6_held_before_reset", 32'(vec_valid), 32'd1);
    s_valid = 1'b1; s_data = fp(315); rst_n = 1'b0;
    #1;
    chk("t6_reset_vec_valid", 32'(vec_valid), 32'd0);
    chk("t6_reset_s_ready", 32'(s_ready), 32'd0);
    s_valid = 1'b0;
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    vec_ready = 1'b1;
    for (int i = 1; i <= NUM_IN; i++) send(fp(400 + i), i == NUM_IN);
    tick();
    chk("t6_fresh_valid", 32'(vec_valid), 32'd1);
    chk("t6_fresh_word0", word_of(vec_out, 0), fp(401));
    chk("t6_fresh_word29", word_of(vec_out, 29), fp(430));
    drain();

    // Randomized words, gaps, lengths and consumer back-pressure
    rdy_rand = 1'b1;
    for (int v = 0; v < 40; v++) begin
      int kind;
      int len;
      kind = int'($urandom_range(0, 9));
      len  = NUM_IN;
      if (kind == 0) len = int'($urandom_range(1, NUM_IN - 1));
      for (int i = 0; i < len; i++) begin
        if ($urandom_range(0, 3) == 0) tick();
        send($urandom(), (i == len - 1) && (kind != 1));
      end
    end
    rdy_rand = 1'b0;
    drain();
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
